seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 123 ++++++++++++
 tb/tb_seg_scan_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit multiplexed seven-segment driver for packed BCD with sign digit
//
// Scans a latched {sign, hundreds, tens, ones} value onto a common-anode
// display, one digit per REFRESH_DIV cycles. New values are taken only at
// the frame boundary so a frame never mixes two numbers.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   bcd_in      packed BCD [11:8] hundreds, [7:4] tens, [3:0] ones
//   neg_in      sign flag qualified with bcd_in (1 = minus)
//   bcd_valid   single-cycle strobe sampling bcd_in / neg_in
//   blank_en    level, 1 = suppress leading zeros
//   an          anode enables, active low (an[0] ones, an[3] sign)
//   seg         segments {g,f,e,d,c,b,a}, active low
//   dp          decimal point, active low, always off
//   frame_done  one-cycle pulse on the first cycle of each new frame
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bcd_in,
    input  logic        neg_in,
    input  logic        bcd_valid,
    input  logic        blank_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    // Low during reset; the first edge after release lights digit 0 without
    // advancing the counter, so digit 0 gets its full REFRESH_DIV cycles.
    logic          running;
    logic [12:0]   pending;   // {sign, hundreds, tens, ones}
    logic [12:0]   shadow;

    logic          tc;
    logic          boundary;
    logic [1:0]    next_idx;
    logic [12:0]   next_shadow;
    logic [6:0]    next_seg;

    function automatic logic [6:0] encode(input logic [3:0] nib);
        case (nib)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b0000110;  // "E" for non-decimal nibbles
        endcase
    endfunction

    always_comb begin
        tc       = running && (cnt == CNT_MAX);
        boundary = tc && (idx == 2'd3);
        next_idx = tc ? idx + 2'd1 : idx;

        // On the boundary a same-cycle strobe bypasses pending straight into
        // the shadow, so the value shows in the very next digit-0 slot.
        next_shadow = shadow;
        if (boundary) begin
            next_shadow = bcd_valid ? {neg_in, bcd_in} : pending;
        end

        // Outputs are decoded from the post-edge index and shadow so an/seg
        // change on the same edge as the index.
        next_seg = SEG_BLANK;
        case (next_idx)
            2'd0: next_seg = encode(next_shadow[3:0]);
            2'd1: next_seg = (blank_en && next_shadow[11:8] == 4'd0 && next_shadow[7:4] == 4'd0)
                             ? SEG_BLANK : encode(next_shadow[7:4]);
            2'd2: next_seg = (blank_en && next_shadow[11:8] == 4'd0)
                             ? SEG_BLANK : encode(next_shadow[11:8]);
            2'd3: next_seg = next_shadow[12] ? SEG_MINUS : SEG_BLANK;
            default: next_seg = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            running    <= 1'b0;
            pending    <= '0;
            shadow     <= '0;
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            running <= 1'b1;
            if (running) begin
                cnt <= tc ? '0 : cnt + CW'(1);
            end
            idx        <= next_idx;
            shadow     <= next_shadow;
            if (bcd_valid) begin
                pending <= {neg_in, bcd_in};
            end
            an         <= ~(4'b0001 << next_idx);
            seg        <= next_seg;
            frame_done <= boundary;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] bcd_in;
    logic        neg_in;
    logic        bcd_valid;
    logic        blank_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] BL = 7'b1111111;

    seg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .neg_in     (neg_in),
        .bcd_valid  (bcd_valid),
        .blank_en   (blank_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_seg(input string tag, input logic [6:0] exp);
        tests++;
        assert (seg === exp) else begin
            fails++;
            $error("FAIL %s: seg observed %b expected %b", tag, seg, exp);
        end
    endtask

    task automatic chk_an(input string tag, input logic [3:0] exp);
        tests++;
        assert (an === exp) else begin
            fails++;
            $error("FAIL %s: an observed %b expected %b", tag, an, exp);
        end
    endtask

    task automatic chk_fd(input string tag, input logic exp);
        tests++;
        assert (frame_done === exp) else begin
            fails++;
            $error("FAIL %s: frame_done observed %b expected %b", tag, frame_done, exp);
        end
    endtask

    task automatic strobe(input logic [11:0] v, input logic n);
        bcd_in    = v;
        neg_in    = n;
        bcd_valid = 1'b1;
        tick(1);
        bcd_valid = 1'b0;
    endtask

    // Leaves the bench on the first cycle of a new frame (digit 0 lit).
    task automatic wait_fd(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (frame_done === 1'b1) break;
            tick(1);
        end
        chk_fd(tag, 1'b1);
    endtask

    task automatic wait_an(input string tag, input logic [3:0] target);
        for (int i = 0; i < 40; i++) begin
            if (an === target) break;
            tick(1);
        end
        chk_an(tag, target);
    endtask

    // Starts on digit 0, ends on the first cycle of digit 3.
    task automatic show_frame(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                              input logic [6:0] d2, input logic [6:0] d3);
        chk_an({tag, "_an0"}, 4'b1110);
        chk_seg({tag, "_ones"}, d0);
        tick(4);
        chk_an({tag, "_an1"}, 4'b1101);
        chk_seg({tag, "_tens"}, d1);
        tick(4);
        chk_an({tag, "_an2"}, 4'b1011);
        chk_seg({tag, "_hund"}, d2);
        tick(4);
        chk_an({tag, "_an3"}, 4'b0111);
        chk_seg({tag, "_sign"}, d3);
    endtask

    initial begin
        logic [3:0] exp_an;

        reset     = 1'b1;
        bcd_in    = 12'h000;
        neg_in    = 1'b0;
        bcd_valid = 1'b0;
        blank_en  = 1'b0;
        tick(3);
        chk_an("rst_an", 4'b1111);
        chk_seg("rst_seg", BL);
        chk_fd("rst_fd", 1'b0);
        tests++;
        assert (dp === 1'b1) else begin
            fails++;
            $error("FAIL rst_dp: dp observed %b expected 1", dp);
        end

        // Release: digit 0 lit on the first cycle, then 4 cycles per digit.
        reset = 1'b0;
        tick(1);
        chk_seg("first_seg", 7'b1000000);
        for (int k = 0; k < 16; k++) begin
            exp_an = ~(4'b0001 << (k / 4));
            chk_an("walk_an", exp_an);
            chk_fd("walk_fd", 1'b0);
            tick(1);
        end
        chk_fd("frame1_fd", 1'b1);
        chk_an("frame1_an", 4'b1110);
        tick(1);
        chk_fd("fd_one_cycle", 1'b0);

        // Strobe in the middle of digit 1: old value holds until the boundary.
        tick(4);
        strobe(12'h255, 1'b1);
        wait_an("old_sign_an", 4'b0111);
        chk_seg("old_sign_seg", BL);
        wait_fd("fd_255");
        show_frame("v255", 7'b0010010, 7'b0010010, 7'b0100100, 7'b0111111);

        blank_en = 1'b1;
        strobe(12'h007, 1'b0);
        wait_fd("fd_007");
        show_frame("v007", 7'b1111000, BL, BL, BL);

        strobe(12'h070, 1'b0);
        wait_fd("fd_070");
        show_frame("v070", 7'b1000000, 7'b1111000, BL, BL);

        strobe(12'h0A3, 1'b0);
        wait_fd("fd_0a3");
        show_frame("v0a3", 7'b0110000, 7'b0000110, BL, BL);

        // Last of two strobes in one frame wins.
        blank_en = 1'b0;
        strobe(12'h111, 1'b0);
        strobe(12'h999, 1'b0);
        wait_fd("fd_999");
        show_frame("v999", 7'b0010000, 7'b0010000, 7'b0010000, BL);

        // Strobe on the frame-boundary cycle shows in the next digit-0 slot.
        tick(3);
        strobe(12'h468, 1'b0);
        chk_fd("bnd_fd", 1'b1);
        chk_an("bnd_an", 4'b1110);
        chk_seg("bnd_ones", 7'b0000000);
        tick(4);
        chk_seg("bnd_tens", 7'b0000010);
        tick(4);
        chk_seg("bnd_hund", 7'b0011001);

        // Reset mid-digit 2 with a pending value in flight.
        strobe(12'h999, 1'b0);
        wait_fd("fd_999b");
        tick(5);
        strobe(12'h777, 1'b1);
        tick(4);
        chk_an("pre_rst_an", 4'b1011);
        reset = 1'b1;
        tick(1);
        chk_an("mid_rst_an", 4'b1111);
        chk_seg("mid_rst_seg", BL);
        chk_fd("mid_rst_fd", 1'b0);
        tick(1);
        reset = 1'b0;
        tick(1);
        show_frame("post_rst", 7'b1000000, 7'b1000000, 7'b1000000, BL);
        wait_fd("fd_post_rst");
        chk_seg("pending_discarded", 7'b1000000);
        tick(12);
        chk_seg("pending_discarded_sign", BL);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
